// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states plus word width and divider limits.
package spi_pkg;

   localparam int SPI_WORD_W      = 8;
   localparam int SPI_MIN_CLK_DIV = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_WAIT,
      ST_HOLD,
      ST_GAP
   } spi_master_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module spi_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first 8-bit words, multi-byte frames closed by tx_last,
// SCK derived from clk by a CLK_DIV-cycle half-period divider.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       SCK,
   output logic       MOSI,
   output logic       SSEL,
   input  logic       MISO
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_div_check
      $error("spi_master: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
   end

   spi_master_state_t state, state_n;
   logic [DIV_W-1:0] div, div_n;
   logic [2:0] bitcnt, bitcnt_n;
   logic [SPI_WORD_W-1:0] txsh, txsh_n;
   logic [SPI_WORD_W-1:0] rxsh, rxsh_n;
   logic [SPI_WORD_W-1:0] rx_data_n;
   logic last, last_n;
   logic sck_n, mosi_n, ssel_n, rx_valid_n;
   logic miso_s, div_end, accept;

   spi_sync #(.RESET_VAL(1'b0)) u_miso_sync (
      .clk (clk),
      .rst (rst),
      .d   (MISO),
      .q   (miso_s)
   );

   assign tx_ready = (state == ST_IDLE) || (state == ST_WAIT);
   assign busy     = (state != ST_IDLE);
   assign accept   = tx_valid && tx_ready;
   assign div_end  = (div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         div      <= '0;
         bitcnt   <= '0;
         txsh     <= '0;
         rxsh     <= '0;
         last     <= 1'b0;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         SSEL     <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         state    <= state_n;
         div      <= div_n;
         bitcnt   <= bitcnt_n;
         txsh     <= txsh_n;
         rxsh     <= rxsh_n;
         last     <= last_n;
         SCK      <= sck_n;
         MOSI     <= mosi_n;
         SSEL     <= ssel_n;
         rx_valid <= rx_valid_n;
         rx_data  <= rx_data_n;
      end
   end

   always_comb begin
      state_n    = state;
      div_n      = div + 1'b1;
      bitcnt_n   = bitcnt;
      txsh_n     = txsh;
      rxsh_n     = rxsh;
      last_n     = last;
      sck_n      = SCK;
      mosi_n     = MOSI;
      ssel_n     = SSEL;
      rx_valid_n = 1'b0;
      rx_data_n  = rx_data;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               txsh_n   = tx_data;
               last_n   = tx_last;
               bitcnt_n = '0;
               ssel_n   = 1'b0;
               mosi_n   = tx_data[7];
               state_n  = ST_SETUP;
            end
         end
         ST_SETUP, ST_LOW: begin
            if (div_end) begin
               sck_n   = 1'b1;
               rxsh_n  = {rxsh[SPI_WORD_W-2:0], miso_s};
               state_n = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (div_end) begin
               sck_n = 1'b0;
               if (bitcnt != 3'd7) begin
                  // Rotating keeps every shift bit live; only the MSB ever drives MOSI.
                  bitcnt_n = bitcnt + 3'd1;
                  txsh_n   = {txsh[SPI_WORD_W-2:0], txsh[SPI_WORD_W-1]};
                  mosi_n   = txsh[SPI_WORD_W-2];
                  state_n  = ST_LOW;
               end else begin
                  rx_data_n  = rxsh;
                  rx_valid_n = 1'b1;
                  state_n    = last ? ST_HOLD : ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (accept) begin
               txsh_n   = tx_data;
               last_n   = tx_last;
               bitcnt_n = '0;
               mosi_n   = tx_data[7];
               state_n  = ST_LOW;
            end
         end
         ST_HOLD: begin
            if (div_end) begin
               ssel_n  = 1'b1;
               mosi_n  = 1'b0;
               state_n = ST_GAP;
            end
         end
         ST_GAP: begin
            if (div_end) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if ((state_n != state) || (state == ST_IDLE) || (state == ST_WAIT)) begin
         div_n = '0;
      end
   end

endmodule
